cp0_regfile: RTL and testbench

//  Coprocessor-0 register block downstream of the controller's exception outputs (exception/eret/cause).

---
 rtl/cp0_pkg.sv | 60 ++++++
 rtl/cp0_regfile_if.sv | 39 +++
 rtl/cp0_timer.sv | 64 ++++++
 rtl/cp0_regfile.sv | 120 ++++++++++++
 tb/tb_cp0_regfile.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cp0_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cp0_pkg
// Purpose : Shared constants for the CP0 register block: register numbers,
//           exception codes, Status/Cause field positions, packing helpers.
// Rev     : 1.0  initial release
// ============================================================================
package cp0_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    localparam int STATUS_IE     = 0;
    localparam int STATUS_EXL    = 1;
    localparam int STATUS_IM_LO  = 8;
    localparam int STATUS_BEV    = 22;
    localparam int CAUSE_EXC_LO  = 2;
    localparam int CAUSE_IP_LO   = 8;
    localparam int CAUSE_TI      = 30;
    localparam int CAUSE_BD      = 31;

    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

    // Architected Status image: BEV fixed at 1, unimplemented bits read 0.
    function automatic logic [31:0] pack_status(input logic [7:0] im,
                                                input logic       exl,
                                                input logic       ie);
        pack_status                        = STATUS_RESET;
        pack_status[STATUS_IM_LO +: 8]     = im;
        pack_status[STATUS_EXL]            = exl;
        pack_status[STATUS_IE]             = ie;
    endfunction

    function automatic logic [31:0] pack_cause(input logic       bd,
                                               input logic       ti,
                                               input logic [7:0] ip,
                                               input logic [4:0] exc);
        pack_cause                     = 32'h0;
        pack_cause[CAUSE_BD]           = bd;
        pack_cause[CAUSE_TI]           = ti;
        pack_cause[CAUSE_IP_LO +: 8]   = ip;
        pack_cause[CAUSE_EXC_LO +: 5]  = exc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cp0_regfile_if.sv
`default_nettype none
// ============================================================================
// Module  : cp0_regfile_if
// Purpose : Controller <-> CP0 bundle: MTC0/MFC0 access, exception/ERET
//           events, interrupt lines and redirect/status outputs.
// Rev     : 1.0  initial release
// ============================================================================
interface cp0_regfile_if;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic [4:0]  raddr_i;
    logic [31:0] rdata_o;
    logic        exception_i;
    logic [5:0]  cause_i;
    logic [31:0] pc_i;
    logic [31:0] badvaddr_i;
    logic        eret_i;
    logic [5:0]  hw_int_i;
    logic        redirect_o;
    logic [31:0] target_o;
    logic        int_req_o;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;

    modport master (
        output we_i, waddr_i, wdata_i, raddr_i,
        output exception_i, cause_i, pc_i, badvaddr_i, eret_i, hw_int_i,
        input  rdata_o, redirect_o, target_o, int_req_o, status_o, cause_o, epc_o
    );

    modport slave (
        input  we_i, waddr_i, wdata_i, raddr_i,
        input  exception_i, cause_i, pc_i, badvaddr_i, eret_i, hw_int_i,
        output rdata_o, redirect_o, target_o, int_req_o, status_o, cause_o, epc_o
    );
endinterface
`default_nettype wire

// File: rtl/cp0_timer.sv
`default_nettype none
// ============================================================================
// Module  : cp0_timer
// Purpose : Count/Compare timer with clock prescaler and sticky TI flag.
// Rev     : 1.0  initial release
// ============================================================================
module cp0_timer #(
    parameter int COUNT_DIV = 2
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        i_count_we,
    input  wire logic        i_compare_we,
    input  wire logic [31:0] i_wdata,
    output logic      [31:0] o_count,
    output logic      [31:0] o_compare,
    output logic             o_ti
);
    localparam int              c_pw        = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [c_pw-1:0] c_presc_max = c_pw'(COUNT_DIV - 1);

    logic [c_pw-1:0] r_presc;
    logic [31:0]     r_count;
    logic [31:0]     r_compare;
    logic            r_ti;
    logic            w_tick;
    logic [31:0]     w_count_inc;

    assign w_tick      = (r_presc == c_presc_max);
    assign w_count_inc = r_count + 32'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc   <= '0;
            r_count   <= '0;
            r_compare <= '0;
            r_ti      <= 1'b0;
        end else begin
            if (i_count_we) begin
                r_count <= i_wdata;
                r_presc <= '0;
            end else if (w_tick) begin
                r_count <= w_count_inc;
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + 1'b1;
            end

            if (i_compare_we)
                r_compare <= i_wdata;

            // A Compare write beats a same-cycle match so software can always ack.
            if (i_compare_we)
                r_ti <= 1'b0;
            else if (!i_count_we && w_tick && (w_count_inc == r_compare))
                r_ti <= 1'b1;
        end
    end

    assign o_count   = r_count;
    assign o_compare = r_compare;
    assign o_ti      = r_ti;
endmodule
`default_nettype wire

// File: rtl/cp0_regfile.sv
`default_nettype none
// ============================================================================
// Module  : cp0_regfile
// Purpose : CP0 register block: BadVAddr/Count/Compare/Status/Cause/EPC,
//           exception entry/return redirect and interrupt request.
// Rev     : 1.0  initial release
// ============================================================================
module cp0_regfile
    import cp0_pkg::*;
#(
    parameter int          COUNT_DIV = 2,
    parameter logic [31:0] EXC_VEC   = 32'hBFC0_0380
) (
    input  wire logic   clk,
    input  wire logic   rst,
    cp0_regfile_if.slave bus
);
    logic [31:0] r_badvaddr;
    logic [7:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic [7:0]  r_ip;
    logic [4:0]  r_exc;
    logic [31:0] r_epc;

    logic        w_wr;
    logic        w_addr_exc;
    logic [31:0] w_count;
    logic [31:0] w_compare;
    logic        w_ti;
    logic [31:0] w_status;
    logic [31:0] w_cause;
    logic [31:0] w_rdata;

    // An exception in the same cycle squashes the MTC0.
    assign w_wr       = bus.we_i & ~bus.exception_i;
    assign w_addr_exc = (bus.cause_i[4:0] == EXC_ADEL) || (bus.cause_i[4:0] == EXC_ADES);

    cp0_timer #(
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .i_count_we   (w_wr && (bus.waddr_i == CP0_COUNT)),
        .i_compare_we (w_wr && (bus.waddr_i == CP0_COMPARE)),
        .i_wdata      (bus.wdata_i),
        .o_count      (w_count),
        .o_compare    (w_compare),
        .o_ti         (w_ti)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_badvaddr <= '0;
            r_im       <= '0;
            r_exl      <= 1'b0;
            r_ie       <= 1'b0;
            r_bd       <= 1'b0;
            r_ip       <= '0;
            r_exc      <= '0;
            r_epc      <= '0;
        end else begin
            // IP7 doubles as the timer interrupt line.
            r_ip[7:2] <= {bus.hw_int_i[5] | w_ti, bus.hw_int_i[4:0]};

            if (w_wr) begin
                case (bus.waddr_i)
                    CP0_STATUS: begin
                        r_im  <= bus.wdata_i[STATUS_IM_LO +: 8];
                        r_exl <= bus.wdata_i[STATUS_EXL];
                        r_ie  <= bus.wdata_i[STATUS_IE];
                    end
                    CP0_CAUSE: r_ip[1:0] <= bus.wdata_i[CAUSE_IP_LO +: 2];
                    CP0_EPC:   r_epc     <= bus.wdata_i;
                    default: ;
                endcase
            end

            if (bus.exception_i) begin
                r_exc <= bus.cause_i[4:0];
                r_exl <= 1'b1;
                // Nested exceptions keep the original return point.
                if (!r_exl) begin
                    r_epc <= bus.cause_i[5] ? (bus.pc_i - 32'd4) : bus.pc_i;
                    r_bd  <= bus.cause_i[5];
                end
                if (w_addr_exc)
                    r_badvaddr <= bus.badvaddr_i;
            end else if (bus.eret_i) begin
                r_exl <= 1'b0;
            end
        end
    end

    assign w_status = pack_status(r_im, r_exl, r_ie);
    assign w_cause  = pack_cause(r_bd, w_ti, r_ip, r_exc);

    always_comb begin
        w_rdata = '0;
        case (bus.raddr_i)
            CP0_BADVADDR: w_rdata = r_badvaddr;
            CP0_COUNT:    w_rdata = w_count;
            CP0_COMPARE:  w_rdata = w_compare;
            CP0_STATUS:   w_rdata = w_status;
            CP0_CAUSE:    w_rdata = w_cause;
            CP0_EPC:      w_rdata = r_epc;
            default:      w_rdata = '0;
        endcase
    end

    assign bus.rdata_o    = w_rdata;
    assign bus.redirect_o = bus.exception_i | bus.eret_i;
    assign bus.target_o   = bus.exception_i ? EXC_VEC : r_epc;
    assign bus.int_req_o  = r_ie & ~r_exl & (|(r_ip & r_im));
    assign bus.status_o   = w_status;
    assign bus.cause_o    = w_cause;
    assign bus.epc_o      = r_epc;
endmodule
`default_nettype wire

// File: tb/tb_cp0_regfile.sv
`default_nettype none
// ============================================================================
// Module  : tb_cp0_regfile
// Purpose : Self-checking bench for cp0_regfile: directed scenarios plus
//           randomized traffic against a word-level reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_cp0_regfile;
    localparam int          c_div    = 2;
    localparam logic [31:0] c_vec    = 32'hBFC0_0380;
    localparam logic [31:0] c_st_rst = 32'h0040_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    cp0_regfile_if bus ();

    cp0_regfile #(.COUNT_DIV(c_div), .EXC_VEC(c_vec)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference state kept as whole architectural words.
    logic [31:0] m_status, m_cause, m_epc, m_badv, m_count, m_compare;
    int          m_presc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_status = c_st_rst; m_cause = '0; m_epc = '0; m_badv = '0;
        m_count = '0; m_compare = '0; m_presc = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        case (a)
            5'd8:    return m_badv;
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_status;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_step();
        logic        wr;
        logic        ti_old, ti;
        logic [31:0] ns, nc;
        wr     = bus.we_i && !bus.exception_i;
        ti_old = m_cause[30];
        ti     = ti_old;
        ns     = m_status;
        nc     = m_cause;
        if (wr && bus.waddr_i == 5'd9) begin
            m_count = bus.wdata_i;
            m_presc = 0;
        end else begin
            m_presc++;
            if (m_presc == c_div) begin
                m_presc = 0;
                m_count = m_count + 1;
                if (m_count == m_compare) ti = 1'b1;
            end
        end
        if (wr && bus.waddr_i == 5'd11) begin
            m_compare = bus.wdata_i;
            ti = 1'b0;
        end
        if (wr && bus.waddr_i == 5'd12) ns = c_st_rst | (bus.wdata_i & 32'h0000_FF03);
        if (wr && bus.waddr_i == 5'd13) nc = (nc & ~32'h300) | (bus.wdata_i & 32'h300);
        if (wr && bus.waddr_i == 5'd14) m_epc = bus.wdata_i;
        if (bus.exception_i) begin
            nc = (nc & ~32'h7C) | ({27'b0, bus.cause_i[4:0]} << 2);
            if (!m_status[1]) begin
                m_epc  = bus.cause_i[5] ? bus.pc_i - 32'd4 : bus.pc_i;
                nc[31] = bus.cause_i[5];
            end
            ns[1] = 1'b1;
            if (bus.cause_i[4:0] == 5'd4 || bus.cause_i[4:0] == 5'd5) m_badv = bus.badvaddr_i;
        end else if (bus.eret_i) begin
            ns[1] = 1'b0;
        end
        nc[15:10] = {bus.hw_int_i[5] | ti_old, bus.hw_int_i[4:0]};
        nc[30]    = ti;
        m_status  = ns;
        m_cause   = nc;
    endtask

    task automatic check_outputs();
        logic ir;
        ir = m_status[0] & ~m_status[1] & (|(m_cause[15:8] & m_status[15:8]));
        chk("rdata",    bus.rdata_o,            model_read(bus.raddr_i));
        chk("redirect", {31'b0, bus.redirect_o}, {31'b0, bus.exception_i | bus.eret_i});
        chk("target",   bus.target_o,           bus.exception_i ? c_vec : m_epc);
        chk("int_req",  {31'b0, bus.int_req_o}, {31'b0, ir});
        chk("status",   bus.status_o,           m_status);
        chk("cause",    bus.cause_o,            m_cause);
        chk("epc",      bus.epc_o,              m_epc);
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        if (rst) model_step(); else model_reset();
        #1;
    endtask

    task automatic idle();
        bus.we_i = 1'b0; bus.exception_i = 1'b0; bus.eret_i = 1'b0;
        bus.cause_i = '0; bus.hw_int_i = '0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        bus.we_i = 1'b1; bus.waddr_i = a; bus.wdata_i = d;
        cycle();
        idle();
        #1;
    endtask

    task automatic take_exc(input logic [5:0] c, input logic [31:0] pc, input logic [31:0] bv);
        bus.exception_i = 1'b1; bus.cause_i = c; bus.pc_i = pc; bus.badvaddr_i = bv;
        #1;
        chk("exc_target", bus.target_o, c_vec);
        cycle();
        idle();
        #1;
    endtask

    task automatic do_eret(input logic [31:0] exp_tgt);
        bus.eret_i = 1'b1;
        #1;
        chk("eret_target", bus.target_o, exp_tgt);
        cycle();
        idle();
        #1;
        chk("eret_exl", {31'b0, bus.status_o[1]}, 32'h0);
    endtask

    function automatic logic [4:0] pick_addr();
        case ($urandom_range(0, 7))
            0:       return 5'd8;
            1:       return 5'd9;
            2:       return 5'd11;
            3:       return 5'd12;
            4:       return 5'd13;
            5:       return 5'd14;
            6:       return 5'd3;
            default: return 5'($urandom);
        endcase
    endfunction

    initial begin
        idle();
        bus.waddr_i = '0; bus.wdata_i = '0; bus.raddr_i = 5'd9;
        bus.pc_i = '0; bus.badvaddr_i = '0;
        model_reset();
        #2;
        chk("rst_status",   bus.status_o, 32'h0040_0000);
        chk("rst_cause",    bus.cause_o,  32'h0);
        chk("rst_epc",      bus.epc_o,    32'h0);
        chk("rst_count",    bus.rdata_o,  32'h0);
        chk("rst_redirect", {31'b0, bus.redirect_o}, 32'h0);
        chk("rst_intreq",   {31'b0, bus.int_req_o},  32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        cycle();
        cycle();
        chk("count_after_2", bus.rdata_o, 32'h1);

        // Syscall entry and return
        bus.raddr_i = 5'd14;
        take_exc(6'h08, 32'hBFC0_0100, 32'h0);
        chk("sys_epc", bus.epc_o, 32'hBFC0_0100);
        chk("sys_exccode", {27'b0, bus.cause_o[6:2]}, 32'd8);
        chk("sys_exl", {31'b0, bus.status_o[1]}, 32'h1);
        do_eret(32'hBFC0_0100);

        // Delay-slot address error, then a nested exception
        bus.raddr_i = 5'd8;
        take_exc(6'h24, 32'h0000_1000, 32'h0000_1233);
        chk("ds_epc", bus.epc_o, 32'h0000_0FFC);
        chk("ds_bd", {31'b0, bus.cause_o[31]}, 32'h1);
        chk("ds_badv", bus.rdata_o, 32'h0000_1233);
        take_exc(6'h0A, 32'h0000_2000, 32'h0);
        chk("nested_epc", bus.epc_o, 32'h0000_0FFC);
        do_eret(32'h0000_0FFC);

        // Exception and ERET together: exception wins
        bus.exception_i = 1'b1; bus.eret_i = 1'b1; bus.cause_i = 6'h09; bus.pc_i = 32'h0000_4000;
        #1;
        chk("exc_eret_target", bus.target_o, c_vec);
        cycle(); idle(); #1;
        chk("exc_eret_exl", {31'b0, bus.status_o[1]}, 32'h1);
        chk("exc_eret_epc", bus.epc_o, 32'h0000_4000);
        do_eret(32'h0000_4000);

        // Timer match and interrupt
        mtc0(5'd11, 32'd5);
        mtc0(5'd9,  32'd3);
        repeat (3) cycle();
        chk("ti_early", {31'b0, bus.cause_o[30]}, 32'h0);
        cycle();
        chk("ti_set", {31'b0, bus.cause_o[30]}, 32'h1);
        cycle();
        chk("ip7_set", {31'b0, bus.cause_o[15]}, 32'h1);
        mtc0(5'd12, 32'h0000_8001);
        chk("int_req_on", {31'b0, bus.int_req_o}, 32'h1);
        mtc0(5'd11, 32'h0000_1000);
        chk("ti_clr", {31'b0, bus.cause_o[30]}, 32'h0);
        cycle();
        chk("int_req_off", {31'b0, bus.int_req_o}, 32'h0);

        // Dropped and ignored writes
        bus.we_i = 1'b1; bus.waddr_i = 5'd14; bus.wdata_i = 32'hDEAD_BEEF;
        take_exc(6'h00, 32'h0000_3000, 32'h0);
        chk("drop_epc", bus.epc_o, 32'h0000_3000);
        mtc0(5'd8, 32'h1234_5678);
        mtc0(5'd3, 32'hFFFF_FFFF);
        bus.raddr_i = 5'd8; #1;
        chk("ro_badv", bus.rdata_o, 32'h0000_1233);
        bus.raddr_i = 5'd3; #1;
        chk("unmapped", bus.rdata_o, 32'h0);

        // Randomized traffic against the model, with one mid-run reset
        for (int i = 0; i < 1500; i++) begin
            bus.we_i        = ($urandom_range(0, 2) == 0);
            bus.waddr_i     = pick_addr();
            bus.wdata_i     = $urandom_range(0, 1) ? 32'($urandom_range(0, 40)) : $urandom;
            bus.raddr_i     = pick_addr();
            bus.exception_i = ($urandom_range(0, 15) == 0);
            bus.cause_i     = 6'($urandom);
            bus.pc_i        = $urandom;
            bus.badvaddr_i  = $urandom;
            bus.eret_i      = ($urandom_range(0, 9) == 0);
            bus.hw_int_i    = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h0;
            if (i == 700) begin
                rst = 1'b0;
                #1;
                model_reset();
                chk("async_rst_status", bus.status_o, 32'h0040_0000);
                chk("async_rst_epc",    bus.epc_o,    32'h0);
                chk("async_rst_cause",  bus.cause_o,  32'h0);
                cycle();
                rst = 1'b1;
            end
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
